// File: rtl/uart_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : uart_frame_loader
//  Description : Frames a UART byte stream on a sync byte, packs byte pairs
//                into 12-bit RGB pixels stored in a 160x120 framebuffer, and
//                serves the buffer to the VGA stage with 4x upscaling.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_frame_loader #(
  parameter int unsigned IMG_W       = 160,
  parameter int unsigned IMG_H       = 120,
  parameter int unsigned SCALE_SHIFT = 2,
  parameter int unsigned ACTIVE_HORI = 640,
  parameter int unsigned ACTIVE_VERT = 480,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  output logic [11:0] rgb_colour,
  output logic        loading,
  output logic        frame_done,
  output logic        frame_error
);

  localparam int unsigned c_depth     = IMG_W * IMG_H;
  localparam logic [14:0] c_last_addr = 15'(c_depth - 1);
  localparam logic [15:0] c_img_w     = 16'(IMG_W);
  localparam logic [9:0]  c_act_h     = 10'(ACTIVE_HORI);
  localparam logic [9:0]  c_act_v     = 10'(ACTIVE_VERT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_LO   = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [14:0] r_wr_addr;
  logic [14:0] w_wr_addr_nxt;
  logic [3:0]  r_hi_nibble;
  logic [3:0]  w_hi_nibble_nxt;
  logic        w_we;
  logic        w_done_nxt;
  logic        w_err_nxt;
  logic        r_frame_done;
  logic        r_frame_error;
  logic [11:0] r_rgb;

  logic [11:0] r_mem [c_depth];

  logic [9:0]  w_img_x;
  logic [9:0]  w_img_y;
  logic [14:0] w_rd_addr;
  logic        w_visible;

  // Write-side state, address and red-nibble holding registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_wr_addr     <= '0;
      r_hi_nibble   <= '0;
      r_frame_done  <= 1'b0;
      r_frame_error <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wr_addr     <= w_wr_addr_nxt;
      r_hi_nibble   <= w_hi_nibble_nxt;
      r_frame_done  <= w_done_nxt;
      r_frame_error <= w_err_nxt;
    end
  end

  // Byte-protocol decoding: only strobed bytes move the machine
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_addr_nxt   = r_wr_addr;
    w_hi_nibble_nxt = r_hi_nibble;
    w_we            = 1'b0;
    w_done_nxt      = 1'b0;
    w_err_nxt       = 1'b0;
    if (rx_valid) begin
      case (r_state)
        ST_IDLE: begin
          if (rx_data == SYNC_BYTE) begin
            w_state_nxt   = ST_HI;
            w_wr_addr_nxt = '0;
          end
        end
        ST_HI: begin
          if (rx_data[7:4] == 4'd0) begin
            w_hi_nibble_nxt = rx_data[3:0];
            w_state_nxt     = ST_LO;
          end else if (rx_data == SYNC_BYTE) begin
            // Resync: restart the frame without flagging an error
            w_wr_addr_nxt = '0;
          end else begin
            w_err_nxt   = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
        ST_LO: begin
          // Any byte is pixel data here, the sync value included
          w_we        = 1'b1;
          w_state_nxt = ST_HI;
          if (r_wr_addr == c_last_addr) begin
            w_done_nxt    = 1'b1;
            w_wr_addr_nxt = '0;
            w_state_nxt   = ST_IDLE;
          end else begin
            w_wr_addr_nxt = r_wr_addr + 15'd1;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Framebuffer write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wr_addr] <= {r_hi_nibble, rx_data};
    end
  end

  // Screen-to-image address: y*IMG_W built from shifted copies of y
  always_comb begin
    w_img_x   = h_count >> SCALE_SHIFT;
    w_img_y   = v_count >> SCALE_SHIFT;
    w_visible = (h_count < c_act_h) && (v_count < c_act_v);
    w_rd_addr = 15'(w_img_x);
    for (int i = 0; i < 16; i++) begin
      if (c_img_w[i]) begin
        w_rd_addr = w_rd_addr + (15'(w_img_y) << i);
      end
    end
  end

  // Registered read port; blanking forces black and skips the RAM read
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rgb <= '0;
    end else if (w_visible) begin
      r_rgb <= r_mem[w_rd_addr];
    end else begin
      r_rgb <= '0;
    end
  end

  assign rgb_colour  = r_rgb;
  assign loading     = (r_state != ST_IDLE);
  assign frame_done  = r_frame_done;
  assign frame_error = r_frame_error;

endmodule
`default_nettype wire

// File: tb/tb_uart_frame_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_frame_loader
//  Description : Self-checking bench for uart_frame_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_frame_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic [11:0] rgb_colour;
  logic        loading;
  logic        frame_done;
  logic        frame_error;

  uart_frame_loader dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_valid    (rx_valid),
    .rx_data     (rx_data),
    .h_count     (h_count),
    .v_count     (v_count),
    .rgb_colour  (rgb_colour),
    .loading     (loading),
    .frame_done  (frame_done),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic [11:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [11:0] exp;
    string       name;
  } sb_t;

  sb_t  sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_done_pulses = 0;
  int   n_err_pulses  = 0;

  // Pulse counters sampled mid-cycle
  always @(negedge clk) begin
    if (frame_done)  n_done_pulses++;
    if (frame_error) n_err_pulses++;
  end

  function automatic logic [11:0] frame_pix(input int n);
    logic [14:0] nn;
    nn = 15'(n);
    return {nn[3:0], nn[11:4]};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1: drive one strobed byte for one clock
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_pix(input logic [11:0] p);
    send_byte({4'h0, p[11:8]});
    send_byte(p[7:0]);
  endtask

  // Present counts, queue the expectation, compare one clock later
  task automatic rd(input logic [9:0] h, input logic [9:0] v,
                    input logic [11:0] exp, input string name);
    sb_t e;
    h_count = h;
    v_count = v;
    sb_q.push_back('{exp: exp, name: name});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check(e.name, 32'(rgb_colour), 32'(e.exp));
  endtask

  task automatic rd_addr(input int a, input logic [11:0] exp, input string name);
    rd(10'((a % 160) * 4), 10'((a / 160) * 4), exp, name);
  endtask

  vec_t vecs[12];

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    h_count  = 10'd0;
    v_count  = 10'd0;

    vecs[0]  = '{10'd0,   10'd0,   frame_pix(0),     "corner_0_0"};
    vecs[1]  = '{10'd636, 10'd0,   frame_pix(159),   "corner_159_0"};
    vecs[2]  = '{10'd0,   10'd476, frame_pix(19040), "corner_0_119"};
    vecs[3]  = '{10'd636, 10'd476, frame_pix(19199), "corner_159_119"};
    vecs[4]  = '{10'd3,   10'd2,   frame_pix(0),     "scale_3_2"};
    vecs[5]  = '{10'd4,   10'd3,   frame_pix(1),     "scale_4_3"};
    vecs[6]  = '{10'd5,   10'd6,   frame_pix(161),   "scale_5_6"};
    vecs[7]  = '{10'd639, 10'd0,   frame_pix(159),   "edge_639_0"};
    vecs[8]  = '{10'd640, 10'd0,   12'h000,          "blank_h640"};
    vecs[9]  = '{10'd0,   10'd479, frame_pix(19040), "edge_0_479"};
    vecs[10] = '{10'd0,   10'd480, 12'h000,          "blank_v480"};
    vecs[11] = '{10'd1023,10'd1023,12'h000,          "blank_max"};

    // Reset for two clocks
    repeat (2) @(posedge clk);
    #1;
    check("rst_rgb",   32'(rgb_colour),  32'h0);
    check("rst_load",  32'(loading),     32'h0);
    check("rst_done",  32'(frame_done),  32'h0);
    check("rst_err",   32'(frame_error), 32'h0);
    rst_n = 1'b1;

    // Bytes with no sync are ignored
    send_byte(8'h00);
    send_byte(8'h3C);
    check("nosync_load", 32'(loading), 32'h0);
    check("nosync_err",  32'(n_err_pulses), 32'h0);

    // Full frame
    send_byte(8'hA5);
    check("sync_load", 32'(loading), 32'h1);
    for (int n = 0; n < 19199; n++) send_pix(frame_pix(n));
    send_byte({4'h0, frame_pix(19199)[11:8]});
    check("pre_last_load", 32'(loading),    32'h1);
    check("pre_last_done", 32'(frame_done), 32'h0);
    send_byte(frame_pix(19199)[7:0]);
    check("last_done", 32'(frame_done), 32'h1);
    check("last_load", 32'(loading),    32'h0);
    @(posedge clk);
    #1;
    check("done_pulse_end", 32'(frame_done), 32'h0);
    check("done_count",     32'(n_done_pulses), 32'h1);

    // Read-back, scaling and blanking table
    foreach (vecs[i]) rd(vecs[i].h, vecs[i].v, vecs[i].exp, vecs[i].name);

    // Resync within a frame
    send_byte(8'hA5);
    send_byte(8'h0F);
    send_byte(8'hFF);
    send_byte(8'hA5);
    check("resync_err",  32'(n_err_pulses), 32'h0);
    check("resync_load", 32'(loading), 32'h1);
    rd_addr(0, 12'hFFF, "resync_pix0");
    send_pix(12'h123);
    rd_addr(0, 12'h123, "resync_rewrite0");
    rd_addr(1, frame_pix(1), "resync_pix1_kept");

    // Protocol error: resync then bad HI byte
    send_byte(8'hA5);
    send_byte(8'h7E);
    check("err_pulse", 32'(frame_error), 32'h1);
    check("err_load",  32'(loading),     32'h0);
    @(posedge clk);
    #1;
    check("err_pulse_end", 32'(frame_error), 32'h0);
    check("err_count",     32'(n_err_pulses), 32'h1);

    // Sync byte as pixel data
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'hA5);
    check("syncdata_load", 32'(loading), 32'h1);
    rd_addr(0, 12'h1A5, "syncdata_pix0");

    // Reset mid-frame after 100 pixels
    send_byte(8'hA5);
    for (int n = 0; n < 100; n++) send_pix({4'h5, 8'(n + 8'h30)});
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("midrst_load", 32'(loading), 32'h0);
    check("midrst_rgb",  32'(rgb_colour), 32'h0);
    rd_addr(0,   12'h530, "midrst_pix0");
    rd_addr(99,  12'h593, "midrst_pix99");
    rd_addr(100, frame_pix(100), "midrst_pix100");
    send_byte(8'hA5);
    send_pix(12'hCDE);
    rd_addr(0, 12'hCDE, "restart_pix0");
    rd_addr(1, 12'h531, "restart_pix1");
    check("final_done_count", 32'(n_done_pulses), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
